squawk_code_entry: RTL and testbench

Upstream front-end for the transponder top. It turns the raw active-low keys con0/con1/con2 and the edit switch w into a debounced 4-digit octal squawk code.
- Manages an edit buffer with a digit cursor, commits codes on request, and flags emergency codes (7500/7600/7700).
- Outputs feed the transponder's 7-segment drivers (bs0..bs3), beeper and LT24 status display.

---
 rtl/squawk_pkg.sv | 46 ++++
 rtl/key_debounce.sv | 52 +++++
 rtl/squawk_code_entry.sv | 133 +++++++++++++
 tb/tb_squawk_code_entry.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/squawk_pkg.sv
// Shared types, squawk constants and code helpers for the squawk code entry front-end.
package squawk_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ALERT  = 2'd3
    } state_t;

    localparam logic [11:0] SQUAWK_HIJACK  = 12'o7500;
    localparam logic [11:0] SQUAWK_RADIO   = 12'o7600;
    localparam logic [11:0] SQUAWK_EMERG   = 12'o7700;
    localparam logic [11:0] SQUAWK_DEFAULT = 12'o7000;

    localparam logic [1:0] EMERG_NONE   = 2'b00;
    localparam logic [1:0] EMERG_HIJACK = 2'b01;
    localparam logic [1:0] EMERG_RADIO  = 2'b10;
    localparam logic [1:0] EMERG_EMERG  = 2'b11;

    function automatic logic [1:0] emergency_of(input logic [11:0] code);
        logic [1:0] e;
        e = EMERG_NONE;
        case (code)
            SQUAWK_HIJACK: e = EMERG_HIJACK;
            SQUAWK_RADIO:  e = EMERG_RADIO;
            SQUAWK_EMERG:  e = EMERG_EMERG;
            default:       e = EMERG_NONE;
        endcase
        return e;
    endfunction

    // Cursor 0 selects the leftmost digit; the 3-bit add wraps 7 to 0.
    function automatic logic [11:0] bump_digit(input logic [11:0] code, input logic [1:0] cur);
        logic [11:0] r;
        r = code;
        case (cur)
            2'd0:    r[11:9] = code[11:9] + 3'd1;
            2'd1:    r[8:6]  = code[8:6]  + 3'd1;
            2'd2:    r[5:3]  = code[5:3]  + 3'd1;
            default: r[2:0]  = code[2:0]  + 3'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debouncer for one key or switch; press pulses on an
// accepted 1->0 transition, one cycle after the accepted level changes.
module key_debounce #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_prev;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
            r_level <= IDLE_LEVEL;
            r_prev  <= IDLE_LEVEL;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_level;
            r_press <= r_prev & ~r_level;
            // Counts consecutive samples that disagree with the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/squawk_code_entry.sv
// Squawk code entry: debounced keys drive a 4-digit octal edit buffer with cursor,
// commit to the active code, and an alert beep window after emergency codes.
//
//   state     | meaning
//   LOCKED    | edit switch off; keys ignored, edit buffer mirrors active code
//   EDIT      | cursor/increment/commit keys accepted
//   COMMIT    | one cycle; active code just loaded, code_valid high
//   ALERT     | emergency code committed; beep window running, keys ignored
module squawk_code_entry
    import squawk_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          ALERT_CYCLES    = 1024,
    parameter logic [11:0] RESET_CODE      = SQUAWK_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        con0,
    input  logic        con1,
    input  logic        con2,
    input  logic        w,
    output logic [11:0] edit_code,
    output logic [11:0] active_code,
    output logic [1:0]  cursor,
    output logic        editing,
    output logic        code_valid,
    output logic [1:0]  emergency,
    output logic        beep_req
);

    localparam int ACW = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
    localparam logic [ACW-1:0] ALERT_LOAD = ACW'(ALERT_CYCLES - 1);

    logic w_adv, w_inc, w_commit, w_edit_en;
    logic w_con0_level, w_con1_level, w_con2_level, w_sw_press;
    logic w_unused;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_con0 (
        .clock(clock), .reset(reset), .raw(con0), .level(w_con0_level), .press(w_adv));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_con1 (
        .clock(clock), .reset(reset), .raw(con1), .level(w_con1_level), .press(w_inc));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_con2 (
        .clock(clock), .reset(reset), .raw(con2), .level(w_con2_level), .press(w_commit));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) u_sw (
        .clock(clock), .reset(reset), .raw(w), .level(w_edit_en), .press(w_sw_press));

    assign w_unused = ^{w_con0_level, w_con1_level, w_con2_level, w_sw_press};

    state_t           r_state;
    logic [11:0]      r_edit_code;
    logic [11:0]      r_active_code;
    logic [1:0]       r_cursor;
    logic             r_editing;
    logic             r_code_valid;
    logic [1:0]       r_emergency;
    logic             r_beep;
    logic [ACW-1:0]   r_alert_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_LOCKED;
            r_edit_code   <= RESET_CODE;
            r_active_code <= RESET_CODE;
            r_cursor      <= 2'd0;
            r_editing     <= 1'b0;
            r_code_valid  <= 1'b0;
            r_emergency   <= EMERG_NONE;
            r_beep        <= 1'b0;
            r_alert_cnt   <= '0;
        end else begin
            r_code_valid <= 1'b0;
            r_emergency  <= emergency_of(r_active_code);
            case (r_state)
                ST_LOCKED: begin
                    r_edit_code <= r_active_code;
                    if (w_edit_en) begin
                        r_state   <= ST_EDIT;
                        r_cursor  <= 2'd0;
                        r_editing <= 1'b1;
                    end
                end
                ST_EDIT: begin
                    // Switch off beats any same-cycle press; presses are prioritised, never queued.
                    if (!w_edit_en) begin
                        r_state     <= ST_LOCKED;
                        r_editing   <= 1'b0;
                        r_edit_code <= r_active_code;
                    end else if (w_commit) begin
                        r_state       <= ST_COMMIT;
                        r_active_code <= r_edit_code;
                        r_code_valid  <= 1'b1;
                    end else if (w_inc) begin
                        r_edit_code <= bump_digit(r_edit_code, r_cursor);
                    end else if (w_adv) begin
                        r_cursor <= r_cursor + 2'd1;
                    end
                end
                ST_COMMIT: begin
                    if (emergency_of(r_active_code) != EMERG_NONE) begin
                        r_state     <= ST_ALERT;
                        r_beep      <= 1'b1;
                        r_alert_cnt <= ALERT_LOAD;
                    end else begin
                        r_state <= ST_EDIT;
                    end
                end
                ST_ALERT: begin
                    if (!w_edit_en) begin
                        r_state     <= ST_LOCKED;
                        r_editing   <= 1'b0;
                        r_beep      <= 1'b0;
                        r_edit_code <= r_active_code;
                    end else if (r_alert_cnt == '0) begin
                        r_state <= ST_EDIT;
                        r_beep  <= 1'b0;
                    end else begin
                        r_alert_cnt <= r_alert_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_LOCKED;
            endcase
        end
    end

    assign edit_code   = r_edit_code;
    assign active_code = r_active_code;
    assign cursor      = r_cursor;
    assign editing     = r_editing;
    assign code_valid  = r_code_valid;
    assign emergency   = r_emergency;
    assign beep_req    = r_beep;

endmodule

// File: tb/tb_squawk_code_entry.sv
// Bench for squawk_code_entry: directed scenarios plus random key activity, all
// checked against a sample-window / digit-array reference model.
module tb_squawk_code_entry;

    localparam int D = 4;
    localparam int A = 8;
    localparam int M_LOCK = 0, M_EDIT = 1, M_COMMIT = 2, M_ALERT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic con0 = 1'b1, con1 = 1'b1, con2 = 1'b1, w = 1'b0;
    logic [11:0] edit_code, active_code;
    logic [1:0]  cursor, emergency;
    logic        editing, code_valid, beep_req;

    squawk_code_entry #(.DEBOUNCE_CYCLES(D), .ALERT_CYCLES(A), .RESET_CODE(12'o7000)) dut (
        .clock(clock), .reset(reset), .con0(con0), .con1(con1), .con2(con2), .w(w),
        .edit_code(edit_code), .active_code(active_code), .cursor(cursor),
        .editing(editing), .code_valid(code_valid), .emergency(emergency), .beep_req(beep_req));

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    int m_mode;
    int m_dig [4];
    int m_act;
    int m_cur;
    bit m_cv;
    int m_emg;
    bit m_beep;
    int m_left;
    bit m_hist [4][D+2];
    bit m_lvl [4];
    bit m_fell [4];
    bit m_press [4];

    logic [30:0] reset_vec;
    wire  [30:0] dut_vec = {edit_code, active_code, cursor, editing, code_valid, emergency, beep_req};

    function automatic int emg_of(int c);
        if (c == 'o7500) return 1;
        if (c == 'o7600) return 2;
        if (c == 'o7700) return 3;
        return 0;
    endfunction

    function int m_edit_val();
        return m_dig[0] * 512 + m_dig[1] * 64 + m_dig[2] * 8 + m_dig[3];
    endfunction

    function void m_reload();
        for (int k = 0; k < 4; k++) m_dig[k] = (m_act >> (9 - 3 * k)) & 7;
    endfunction

    function logic [30:0] exp_vec();
        return {12'(m_edit_val()), 12'(m_act), 2'(m_cur), (m_mode != M_LOCK), m_cv, 2'(m_emg), m_beep};
    endfunction

    always @(posedge clock) begin : model
        bit raw_now [4];
        bit all_diff;
        bit new_lvl;
        bit wl;
        raw_now[0] = con0; raw_now[1] = con1; raw_now[2] = con2; raw_now[3] = w;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < D + 2; k++) m_hist[i][k] = (i != 3);
                m_lvl[i] = (i != 3);
                m_fell[i] = 1'b0;
                m_press[i] = 1'b0;
            end
            m_mode = M_LOCK; m_act = 'o7000; m_reload();
            m_cur = 0; m_cv = 0; m_emg = 0; m_beep = 0; m_left = 0;
        end else begin
            wl = m_lvl[3];
            m_emg = emg_of(m_act);
            m_cv = 1'b0;
            case (m_mode)
                M_LOCK: begin
                    m_reload();
                    if (wl) begin m_mode = M_EDIT; m_cur = 0; end
                end
                M_EDIT: begin
                    if (!wl) begin m_mode = M_LOCK; m_reload(); end
                    else if (m_press[2]) begin m_act = m_edit_val(); m_cv = 1'b1; m_mode = M_COMMIT; end
                    else if (m_press[1]) m_dig[m_cur] = (m_dig[m_cur] + 1) % 8;
                    else if (m_press[0]) m_cur = (m_cur + 1) % 4;
                end
                M_COMMIT: begin
                    if (emg_of(m_act) != 0) begin m_mode = M_ALERT; m_beep = 1'b1; m_left = A; end
                    else m_mode = M_EDIT;
                end
                default: begin
                    if (!wl) begin m_mode = M_LOCK; m_beep = 1'b0; m_reload(); end
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin m_mode = M_EDIT; m_beep = 1'b0; end
                    end
                end
            endcase
            // A level flips once the last D synchronised samples all disagree with it.
            for (int i = 0; i < 4; i++) begin
                m_press[i] = m_fell[i];
                for (int k = D + 1; k >= 1; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = raw_now[i];
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (m_hist[i][k] == m_lvl[i]) all_diff = 1'b0;
                new_lvl = all_diff ? !m_lvl[i] : m_lvl[i];
                m_fell[i] = m_lvl[i] && !new_lvl;
                m_lvl[i] = new_lvl;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_key(int k, logic v);
        case (k)
            0: con0 = v;
            1: con1 = v;
            default: con2 = v;
        endcase
    endtask

    task automatic tap(int k);
        set_key(k, 1'b0);
        repeat (D + 3) tick();
        set_key(k, 1'b1);
        repeat (D + 3) tick();
    endtask

    task automatic set_code(int tgt);
        int need;
        for (int pos = 0; pos < 4; pos++) begin
            for (int g = 0; g < 4 && m_cur != pos; g++) tap(0);
            need = (((tgt >> (9 - 3 * pos)) & 7) - m_dig[pos] + 8) % 8;
            repeat (need) tap(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; w = 1'b0; con0 = 1'b1; con1 = 1'b1; con2 = 1'b1;
        repeat (3) tick();
        n_total++; if (dut_vec !== reset_vec) $display("FAIL reset_const: got %h expected %h", dut_vec, reset_vec); else n_pass++;
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
        reset = 1'b0;
        repeat (3) tap(1);
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL locked_model: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
        n_total++; if (edit_code !== 12'o7000 || editing !== 1'b0) $display("FAIL locked_ignore: got edit %o editing %b expected 7000 0", edit_code, editing); else n_pass++;
    endtask

    task automatic test_increment();
        w = 1'b1;
        repeat (D + 4) tick();
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL enter_edit: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
        con1 = 1'b0;
        repeat (7) tick();
        n_total++; if (edit_code !== 12'o7000) $display("FAIL inc_latency_before: got %o expected 7000", edit_code); else n_pass++;
        tick();
        n_total++; if (edit_code !== 12'o0000) $display("FAIL inc_latency_after: got %o expected 0000", edit_code); else n_pass++;
        repeat (2) tick();
        con1 = 1'b1;
        repeat (D + 4) tick();
        n_total++; if (edit_code !== 12'o0000 || dut_vec !== exp_vec()) $display("FAIL inc_single: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
    endtask

    task automatic test_cursor();
        int exp_cur [5];
        exp_cur = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            tap(0);
            n_total++; if (cursor !== 2'(exp_cur[i])) $display("FAIL cursor_step%0d: got %0d expected %0d", i, cursor, exp_cur[i]); else n_pass++;
        end
        con0 = 1'b0; tick(); con0 = 1'b1; tick(); con0 = 1'b0; tick(); con0 = 1'b1;
        repeat (10) tick();
        n_total++; if (cursor !== 2'd1 || dut_vec !== exp_vec()) $display("FAIL bounce_ignored: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
    endtask

    task automatic test_emergency();
        int beeps, cvs;
        beeps = 0; cvs = 0;
        set_code('o7700);
        n_total++; if (edit_code !== 12'o7700) $display("FAIL set_7700: got %o expected 7700", edit_code); else n_pass++;
        con2 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c == 8) con2 = 1'b1;
            if (beep_req === 1'b1) beeps++;
            if (code_valid === 1'b1) cvs++;
            n_total++; if (dut_vec !== exp_vec()) $display("FAIL emerg_cycle%0d: got %h expected %h", c, dut_vec, exp_vec()); else n_pass++;
        end
        n_total++; if (beeps != A) $display("FAIL beep_len: got %0d expected %0d", beeps, A); else n_pass++;
        n_total++; if (cvs != 1) $display("FAIL emerg_valid_pulses: got %0d expected 1", cvs); else n_pass++;
        n_total++; if (active_code !== 12'o7700 || emergency !== 2'b11 || editing !== 1'b1 || beep_req !== 1'b0)
            $display("FAIL emerg_final: got active %o emerg %b editing %b beep %b expected 7700 11 1 0", active_code, emergency, editing, beep_req); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int cvs;
        cvs = 0;
        set_code('o1234);
        con1 = 1'b0; con2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 8) begin con1 = 1'b1; con2 = 1'b1; end
            if (code_valid === 1'b1) cvs++;
            n_total++; if (dut_vec !== exp_vec()) $display("FAIL simul_cycle%0d: got %h expected %h", c, dut_vec, exp_vec()); else n_pass++;
        end
        n_total++; if (active_code !== 12'o1234 || edit_code !== 12'o1234 || cvs != 1)
            $display("FAIL simul_commit: got active %o edit %o pulses %0d expected 1234 1234 1", active_code, edit_code, cvs); else n_pass++;
        set_code('o1235);
        n_total++; if (edit_code !== 12'o1235) $display("FAIL set_1235: got %o expected 1235", edit_code); else n_pass++;
        w = 1'b0;
        repeat (D + 6) tick();
        n_total++; if (edit_code !== 12'o1234 || editing !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL lock_discard: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
    endtask

    task automatic test_alert_abort();
        int beeps;
        beeps = 0;
        w = 1'b1;
        repeat (D + 4) tick();
        set_code('o7500);
        con2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 4) w = 1'b0;
            if (c == 7) con2 = 1'b1;
            if (beep_req === 1'b1) beeps++;
            n_total++; if (dut_vec !== exp_vec()) $display("FAIL abort_cycle%0d: got %h expected %h", c, dut_vec, exp_vec()); else n_pass++;
        end
        n_total++; if (beeps != 3) $display("FAIL abort_beep_len: got %0d expected 3", beeps); else n_pass++;
        n_total++; if (editing !== 1'b0 || active_code !== 12'o7500 || emergency !== 2'b01 || edit_code !== 12'o7500)
            $display("FAIL abort_final: got %h expected locked on 7500", dut_vec); else n_pass++;
    endtask

    task automatic test_reset_mid();
        w = 1'b1;
        repeat (D + 4) tick();
        tap(0);
        tap(1);
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL pre_reset: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++; if (dut_vec !== reset_vec) $display("FAIL mid_reset_const: got %h expected %h", dut_vec, reset_vec); else n_pass++;
        n_total++; if (dut_vec !== exp_vec()) $display("FAIL mid_reset_model: got %h expected %h", dut_vec, exp_vec()); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_random();
        int hold [4];
        int shown;
        shown = 0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    set_key(i, (i == 0) ? ~con0 : (i == 1) ? ~con1 : ~con2);
                    hold[i] = $urandom_range(1, 12);
                end else hold[i]--;
            end
            if (hold[3] == 0) begin
                w = ($urandom_range(0, 3) != 0);
                hold[3] = $urandom_range(20, 400);
            end else hold[3]--;
            reset = ($urandom_range(0, 1499) == 0);
            tick();
            n_total++;
            if (dut_vec !== exp_vec()) begin
                if (shown < 10) $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
                shown++;
            end else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset_vec = {12'o7000, 12'o7000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        test_reset();
        test_increment();
        test_cursor();
        test_emergency();
        test_simultaneous();
        test_alert_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
